mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-to-1 multiplexer between four requesters. It picks a winner, drives the mux select, and holds the grant until the winner signals its last beat or drops its request. It then rotates priority to the next requester. It sits in front of the team's 4-to-1 mux datapath and replaces the static Sel stimulus with controlled, fair selection.

---
 rtl/mux4_rr_arbiter_pkg.sv | 13 +
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux_4to1_lane.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4-to-1 mux datapath.
// Package name mux_arb_pkg is imported by the interface, lane mux and arbiter top.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, last flags, lane data and the muxed result.
// master = requester/bench side, slave = arbiter side.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       last;
  logic [NUM_REQ*WIDTH-1:0] d;
  logic [NUM_REQ-1:0]       gnt;
  logic [SEL_W-1:0]         sel;
  logic [WIDTH-1:0]         y;
  logic                     y_valid;
  logic                     busy;

  modport master (
    output req, last, d,
    input  gnt, sel, y, y_valid, busy
  );

  modport slave (
    input  req, last, d,
    output gnt, sel, y, y_valid, busy
  );

endinterface

// File: rtl/mux_4to1_lane.sv
// Purely combinational WIDTH-bit 4-to-1 lane multiplexer; lane i = d[i*WIDTH +: WIDTH].
module mux_4to1_lane
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_REQ*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         y
);

  always_comb begin
    y = d[0 +: WIDTH];
    case (sel)
      2'd0: y = d[0*WIDTH +: WIDTH];
      2'd1: y = d[1*WIDTH +: WIDTH];
      2'd2: y = d[2*WIDTH +: WIDTH];
      2'd3: y = d[3*WIDTH +: WIDTH];
      default: y = d[0 +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters, holding each grant until last/abort.
// Optional macro ARB_TIMEOUT_EN force-releases a grant after MAX_HOLD transferred beats.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   winner;
  logic               valid;
  logic               hold_hit;

  // First requester found scanning upward from the rotating pointer, wrapping mod 4.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // A reset cycle never carries a beat, even if the grant was live.
  assign valid = (state_q == ST_GRANT) && bus.req[sel_q] && !rst;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  assign hold_hit = valid && ((hold_q + 8'd1) == 8'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      hold_q <= 8'd0;
    end else if (valid) begin
      hold_q <= hold_q + 8'd1;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    winner  = rr_pick(bus.req, ptr_q);
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
        end
      end
      ST_GRANT: begin
        // sel is left alone on release so y keeps showing the last lane during the bubble.
        if (!bus.req[sel_q] || bus.last[sel_q] || hold_hit) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  mux_4to1_lane #(.WIDTH(WIDTH)) u_lane (
    .d   (bus.d),
    .sel (sel_q),
    .y   (bus.y)
  );

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y_valid = valid;
  assign bus.busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, directed corner sequences and random traffic
// checked against a bench-side grant/rotation model. Honours ARB_TIMEOUT_EN when defined.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;
  localparam logic [4*WIDTH-1:0] DFIX = 16'h4321;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Reference model: who holds the grant (-1 = nobody), where the search starts, beats so far.
  int mGrant = -1;
  int mPtr   = 0;
  int mSel   = 0;
  int mBeats = 0;

  logic [3:0]       smpGnt;
  logic [1:0]       smpSel;
  logic [WIDTH-1:0] smpY;
  logic             smpValid;
  logic             smpBusy;

  typedef struct {
    logic             r;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic             busy;
    logic [WIDTH-1:0] y;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkVec(logic r, logic [3:0] rq, logic [3:0] ls, logic [3:0] g,
                                 logic [1:0] s, logic v, logic b, logic [WIDTH-1:0] yy);
    vec_t t;
    t.r = r; t.req = rq; t.last = ls; t.gnt = g; t.sel = s; t.valid = v; t.busy = b; t.y = yy;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mGrant = -1;
    mPtr   = 0;
    mSel   = 0;
    mBeats = 0;
  endtask

  // Drive one cycle: inputs set, outputs sampled and checked at negedge, model stepped at posedge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                               input logic [4*WIDTH-1:0] dd);
    int found;
    logic [3:0] expGnt;
    logic expValid;
    rst      = r;
    bus.req  = rq;
    bus.last = ls;
    bus.d    = dd;
    @(negedge clk);
    smpGnt = bus.gnt; smpSel = bus.sel; smpY = bus.y; smpValid = bus.y_valid; smpBusy = bus.busy;
    expGnt   = (mGrant >= 0) ? (4'b0001 << mGrant) : 4'b0000;
    expValid = (mGrant >= 0) && rq[mGrant] && !r;
    checkOutput("model_gnt", 32'(smpGnt), 32'(expGnt));
    checkOutput("model_sel", 32'(smpSel), 32'(mSel));
    checkOutput("model_y_valid", 32'(smpValid), 32'(expValid));
    checkOutput("model_busy", 32'(smpBusy), 32'(mGrant >= 0));
    checkOutput("model_y", 32'(smpY), 32'(dd[mSel*WIDTH +: WIDTH]));
    @(posedge clk);
    if (r) begin
      modelReset();
    end else if (mGrant < 0) begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        if (found < 0 && rq[(mPtr + k) % 4]) found = (mPtr + k) % 4;
      end
      if (found >= 0) begin
        mGrant = found;
        mSel   = found;
        mBeats = 0;
      end
    end else if (!rq[mGrant] || ls[mGrant] || (TIMEOUT_EN && mBeats + 1 == MAX_HOLD)) begin
      mPtr   = (mGrant + 1) % 4;
      mGrant = -1;
    end else begin
      mBeats++;
    end
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 4'b0000, 4'b0000, DFIX);
  endtask

  initial begin
    int validCount;
    rst = 1'b1; bus.req = 4'b1111; bus.last = 4'b0000; bus.d = DFIX;
    @(posedge clk); #1;
    modelReset();

    // Reset with all requesting, then a full rotation with last on every beat.
    vecs[0]  = mkVec(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, 4'h1);
    vecs[1]  = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, 4'h1);
    vecs[2]  = mkVec(0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1, 1, 4'h1);
    vecs[3]  = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, 4'h1);
    vecs[4]  = mkVec(0, 4'b1111, 4'b1111, 4'b0010, 2'd1, 1, 1, 4'h2);
    vecs[5]  = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd1, 0, 0, 4'h2);
    vecs[6]  = mkVec(0, 4'b1111, 4'b1111, 4'b0100, 2'd2, 1, 1, 4'h3);
    vecs[7]  = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd2, 0, 0, 4'h3);
    vecs[8]  = mkVec(0, 4'b1111, 4'b1111, 4'b1000, 2'd3, 1, 1, 4'h4);
    vecs[9]  = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd3, 0, 0, 4'h4);
    vecs[10] = mkVec(0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1, 1, 4'h1);
    vecs[11] = mkVec(0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, 4'h1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].r, vecs[i].req, vecs[i].last, DFIX);
      checkOutput($sformatf("vec%0d_gnt", i), 32'(smpGnt), 32'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d_sel", i), 32'(smpSel), 32'(vecs[i].sel));
      checkOutput($sformatf("vec%0d_valid", i), 32'(smpValid), 32'(vecs[i].valid));
      checkOutput($sformatf("vec%0d_busy", i), 32'(smpBusy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_y", i), 32'(smpY), 32'(vecs[i].y));
    end

    // Single requester on lane 2, three beats, then wrap from pointer 3 and skip to index 3.
    doReset();
    applyStimulus(0, 4'b0100, 4'b0000, DFIX);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(0, 4'b0100, (b == 2) ? 4'b0100 : 4'b0000, DFIX);
      checkOutput("single_gnt", 32'(smpGnt), 32'h4);
      checkOutput("single_valid", 32'(smpValid), 32'h1);
      checkOutput("single_y", 32'(smpY), 32'h3);
    end
    applyStimulus(0, 4'b0010, 4'b0010, DFIX);
    checkOutput("single_release_gnt", 32'(smpGnt), 32'h0);
    applyStimulus(0, 4'b0010, 4'b0010, DFIX);
    checkOutput("wrap_gnt", 32'(smpGnt), 32'h2);
    applyStimulus(0, 4'b1001, 4'b1001, DFIX);
    applyStimulus(0, 4'b1001, 4'b1001, DFIX);
    checkOutput("skip_gnt", 32'(smpGnt), 32'h8);

    // Abort: index 1 drops its request mid-transfer.
    doReset();
    applyStimulus(0, 4'b0010, 4'b0000, DFIX);
    applyStimulus(0, 4'b0010, 4'b0000, DFIX);
    checkOutput("abort_first_beat", 32'(smpValid), 32'h1);
    applyStimulus(0, 4'b0000, 4'b0000, DFIX);
    checkOutput("abort_valid", 32'(smpValid), 32'h0);
    applyStimulus(0, 4'b1111, 4'b0000, DFIX);
    checkOutput("abort_release_gnt", 32'(smpGnt), 32'h0);
    applyStimulus(0, 4'b1111, 4'b0000, DFIX);
    checkOutput("abort_next_gnt", 32'(smpGnt), 32'h4);

    // Reset in the middle of a live grant carries no beat.
    applyStimulus(1, 4'b1111, 4'b0000, DFIX);
    checkOutput("reset_mid_valid", 32'(smpValid), 32'h0);

    // Long hold: lane 0 never signals last.
    doReset();
    applyStimulus(0, 4'b0001, 4'b0000, DFIX);
    validCount = 0;
    for (int c = 0; c < 22; c++) begin
      applyStimulus(0, 4'b0001, 4'b0000, DFIX);
      if (smpValid === 1'b1) validCount++;
    end
    checkOutput("hold_beats", 32'(validCount), TIMEOUT_EN ? 32'd18 : 32'd22);

    // Random traffic with occasional resets.
    doReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
